conv_mac_engine: RTL and testbench

Parametrised, multi-cycle successor to the combinational convolution datapath. It accepts one flattened KMAX x KMAX pixel window and one coefficient window through a valid/ready handshake, and performs one signed MAC per clock over the active k x k region in row-major order. It then applies a programmable arithmetic right shift and either saturation or wrap, and returns the result through a valid/ready output that honours backpressure. It sits between the window buffer and the result writeback in the image-filter pipeline.

---
 rtl/conv_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// Multi-cycle convolution MAC engine: accepts a KMAX x KMAX window and kernel, runs one
// signed MAC per clock over the active k x k region, then shifts and saturates or wraps.
module conv_mac_engine #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int KMAX   = 5,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KMAX*KMAX*PIX_W-1:0] pixels,
    input  logic [KMAX*KMAX*COEF_W-1:0] kernel,
    input  logic [2:0]                 ksize,
    input  logic                       pix_signed,
    input  logic [3:0]                 shift,
    input  logic                       sat_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    result,
    output logic                       ovf,
    output logic                       err
);

    localparam int N      = KMAX * KMAX;
    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = PIX_W + 1 + COEF_W;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [PIX_W-1:0]  pix_a  [N];
    logic [COEF_W-1:0] kern_a [N];
    logic [2:0]        k_r;
    logic              pix_signed_r;
    logic [3:0]        shift_r;
    logic              sat_r;
    logic              bad_k;
    logic [2:0]        row;
    logic [2:0]        col;
    logic signed [ACC_W-1:0] acc;

    logic                     accept;
    logic                     ksize_ok;
    logic                     col_last;
    logic                     last_mac;
    logic [IDX_W-1:0]         idx;
    logic signed [PIX_W:0]    px_ext;
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;
    logic                     ovf_c;
    logic [OUT_W-1:0]         res_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign ksize_ok  = (ksize != 3'd0) && (int'(ksize) <= KMAX);

    assign col_last = (col == k_r - 3'd1);
    assign last_mac = col_last && (row == k_r - 3'd1);

    // Row-major element index within the full KMAX-wide window.
    assign idx    = IDX_W'(row) * IDX_W'(KMAX) + IDX_W'(col);
    assign px_ext = {pix_signed_r & pix_a[idx][PIX_W-1], pix_a[idx]};
    assign coef   = kern_a[idx];
    assign prod   = px_ext * coef;

    assign shifted = acc >>> shift_r;
    assign ovf_c   = (shifted > OUT_MAX) || (shifted < OUT_MIN);

    always_comb begin
        res_c = shifted[OUT_W-1:0];
        if (bad_k) begin
            res_c = '0;
        end else if (sat_r && ovf_c) begin
            res_c = shifted[ACC_W-1] ? OUT_MIN[OUT_W-1:0] : OUT_MAX[OUT_W-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = ksize_ok ? MAC : FIN;
            MAC:  if (last_mac) state_nx = FIN;
            FIN:  state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pix_a[i]  <= '0;
                kern_a[i] <= '0;
            end
            k_r          <= '0;
            pix_signed_r <= 1'b0;
            shift_r      <= '0;
            sat_r        <= 1'b0;
            bad_k        <= 1'b0;
            row          <= '0;
            col          <= '0;
            acc          <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    pix_a[i]  <= pixels[i*PIX_W +: PIX_W];
                    kern_a[i] <= kernel[i*COEF_W +: COEF_W];
                end
                k_r          <= ksize;
                pix_signed_r <= pix_signed;
                shift_r      <= shift;
                sat_r        <= sat_en;
                bad_k        <= !ksize_ok;
                row          <= '0;
                col          <= '0;
                acc          <= '0;
            end else if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                if (col_last) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

    // Output registers load once in FIN and then hold through any backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else if (state == FIN) begin
            result <= res_c;
            ovf    <= bad_k ? 1'b0 : ovf_c;
            err    <= bad_k;
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine with hand-computed expectations.
module tb_conv_mac_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] pixels;
    logic [199:0] kernel;
    logic [2:0]   ksize;
    logic         pix_signed;
    logic [3:0]   shift;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  result;
    logic         ovf;
    logic         err;

    int checks = 0;
    int errors = 0;
    int edges;
    logic busy_ok;
    logic stable_ok;
    logic [15:0] held;

    conv_mac_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixels     (pixels),
        .kernel     (kernel),
        .ksize      (ksize),
        .pix_signed (pix_signed),
        .shift      (shift),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovf        (ovf),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active k x k region gets pv/kv, everything outside gets po/ko.
    task automatic set_win(input int k, input logic [7:0] pv, input logic [7:0] kv,
                           input logic [7:0] po, input logic [7:0] ko);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (r < k && c < k) begin
                    pixels[(r*5+c)*8 +: 8] = pv;
                    kernel[(r*5+c)*8 +: 8] = kv;
                end else begin
                    pixels[(r*5+c)*8 +: 8] = po;
                    kernel[(r*5+c)*8 +: 8] = ko;
                end
            end
        end
    endtask

    task automatic start_op(input int k, input logic ps, input logic [3:0] sh, input logic sat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        ksize      = k[2:0];
        pix_signed = ps;
        shift      = sh;
        sat_en     = sat;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic run_op(input int k, input logic ps, input logic [3:0] sh, input logic sat,
                          output int n, output logic b_ok);
        start_op(k, ps, sh, sat);
        n = 0;
        b_ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) b_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (in_ready) b_ok = 1'b0;
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pixels = '0; kernel = '0; ksize = 3'd0; pix_signed = 1'b0; shift = 4'd0; sat_en = 1'b0;
        #23;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 3x3 unsigned, outside region 0xFF
        set_win(3, 8'd10, 8'd1, 8'hFF, 8'hFF);
        run_op(3, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k3_lat", 32'(edges), 32'd10);
        chk("k3_busy", 32'(busy_ok), 32'd1);
        chk("k3_result", 32'(result), 32'd90);
        chk("k3_ovf", 32'(ovf), 32'd0);
        chk("k3_err", 32'(err), 32'd0);
        finish_out("k3");

        // 2x2 negative saturation, then wrap
        set_win(2, 8'hFF, 8'h80, 8'hFF, 8'hFF);
        run_op(2, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k2sat_lat", 32'(edges), 32'd5);
        chk("k2sat_result", 32'(result), 32'h8000);
        chk("k2sat_ovf", 32'(ovf), 32'd1);
        finish_out("k2sat");
        run_op(2, 1'b0, 4'd0, 1'b0, edges, busy_ok);
        chk("k2wrap_result", 32'(result), 32'h0200);
        chk("k2wrap_ovf", 32'(ovf), 32'd1);
        finish_out("k2wrap");

        // 5x5 with shift
        set_win(5, 8'd200, 8'd1, 8'h00, 8'h00);
        run_op(5, 1'b0, 4'd2, 1'b1, edges, busy_ok);
        chk("k5_lat", 32'(edges), 32'd26);
        chk("k5_result", 32'(result), 32'd1250);
        chk("k5_ovf", 32'(ovf), 32'd0);
        finish_out("k5");

        // 5x5 positive saturation: 25*255*127 = 809625
        set_win(5, 8'd255, 8'd127, 8'h00, 8'h00);
        run_op(5, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k5sat_result", 32'(result), 32'h7FFF);
        chk("k5sat_ovf", 32'(ovf), 32'd1);
        finish_out("k5sat");

        // Signed vs unsigned pixel extension
        set_win(2, 8'hFF, 8'd2, 8'hFF, 8'hFF);
        run_op(2, 1'b1, 4'd0, 1'b1, edges, busy_ok);
        chk("k2s_result", 32'(result), 32'hFFF8);
        chk("k2s_ovf", 32'(ovf), 32'd0);
        finish_out("k2s");
        run_op(2, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k2u_result", 32'(result), 32'd2040);
        finish_out("k2u");

        // -4 >>> 3 floors to -1
        set_win(2, 8'hFF, 8'd1, 8'hFF, 8'hFF);
        run_op(2, 1'b1, 4'd3, 1'b1, edges, busy_ok);
        chk("floor_result", 32'(result), 32'hFFFF);
        finish_out("floor");

        // Backpressure: 7 cycles held, second request ignored
        set_win(3, 8'd10, 8'd1, 8'hFF, 8'hFF);
        run_op(3, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        held = result;
        stable_ok = 1'b1;
        set_win(3, 8'd1, 8'd1, 8'h00, 8'h00);
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== held || ovf !== 1'b0 || err !== 1'b0)
                stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", 32'(stable_ok), 32'd1);
        chk("bp_result", 32'(held), 32'd90);
        finish_out("bp");
        run_op(3, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("bp_next_result", 32'(result), 32'd9);
        finish_out("bp_next");

        // Illegal ksize
        run_op(0, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k0_lat", 32'(edges), 32'd1);
        chk("k0_err", 32'(err), 32'd1);
        chk("k0_result", 32'(result), 32'd0);
        chk("k0_ovf", 32'(ovf), 32'd0);
        finish_out("k0");
        run_op(6, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k6_lat", 32'(edges), 32'd1);
        chk("k6_err", 32'(err), 32'd1);
        chk("k6_result", 32'(result), 32'd0);
        finish_out("k6");
        set_win(3, 8'd10, 8'd1, 8'hFF, 8'hFF);
        run_op(3, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("k3b_err", 32'(err), 32'd0);
        chk("k3b_result", 32'(result), 32'd90);
        finish_out("k3b");

        // Reset during the 4th MAC cycle
        start_op(3, 1'b0, 4'd0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_ovf", 32'(ovf), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        set_win(3, 8'd7, 8'd3, 8'hFF, 8'hFF);
        run_op(3, 1'b0, 4'd0, 1'b1, edges, busy_ok);
        chk("mrst_lat", 32'(edges), 32'd10);
        chk("mrst_fresh_result", 32'(result), 32'd189);
        finish_out("mrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
